// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default bit timing.
// Imported by uart_rx today and by uart_tx later.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_state_e;

    localparam int UART_DEFAULT_CLKS_PER_BIT = 434;
    localparam int UART_DATA_BITS            = 8;

    // Mid-bit offset used to align sampling with the centre of each bit.
    function automatic int uart_half_bit(input int clksPerBit);
        return clksPerBit / 2;
    endfunction

endpackage

// File: rtl/uart_rx_bit_sync.sv
// Two-flop synchronizer for a single asynchronous level.
// The reset value is a parameter so an idle-high line does not look like a start bit.
module bit_sync
    import uart_pkg::*;
#(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: samples mid-bit, delivers each good byte with a one-cycle strobe
// and flags a missing stop bit with a one-cycle error strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] serial_data_in,
    output logic       serial_in_cplt,
    output logic       serial_in_error
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(uart_half_bit(CLKS_PER_BIT) - 1);

    logic          rx_s;
    uart_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [2:0]    bitIdx_q;
    logic [7:0]    shift_q;
    logic [7:0]    data_q;
    logic          cplt_q;
    logic          err_q;

    bit_sync #(
        .RESET_VAL(1'b1)
    ) u_rx_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (rx),
        .q_o  (rx_s)
    );

    // Bit timer saturates at the last count so it never wraps while parked in IDLE.
    assign cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bitIdx_q <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            cplt_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cplt_q <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= cnt_d;
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        cnt_q   <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (cnt_q == CNT_HALF) begin
                        if (!rx_s) begin
                            cnt_q    <= '0;
                            bitIdx_q <= '0;
                            state_q  <= DATA;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        shift_q  <= {rx_s, shift_q[7:1]};
                        cnt_q    <= '0;
                        bitIdx_q <= bitIdx_q + 3'd1;
                        if (bitIdx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end
                end
                // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        if (rx_s) begin
                            data_q  <= shift_q;
                            cplt_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign serial_data_in  = data_q;
    assign serial_in_cplt  = cplt_q;
    assign serial_in_error = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: three receivers (16, 4 and 17 clocks per bit) are driven with
// 8N1 frames and their strobes are compared against a timing/data model built from frame rules.
module tb_uart_rx;

    localparam int CPB0 = 16;
    localparam int CPB1 = 4;
    localparam int CPB2 = 17;

    typedef struct {
        int         sel;
        int         kind;
        int         cyc;
        logic [7:0] data;
    } evt_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxLine   [3];
    logic [7:0] dataOut  [3];
    logic       cpltOut  [3];
    logic       errOut   [3];
    logic [7:0] lastGood [3];

    int   cycle    = 0;
    int   checks   = 0;
    int   failures = 0;
    evt_t expQ[$];
    evt_t obsQ[$];

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    uart_rx #(.CLKS_PER_BIT(CPB0)) dut0 (
        .clk(clk), .rst_n(rst_n), .rx(rxLine[0]),
        .serial_data_in(dataOut[0]), .serial_in_cplt(cpltOut[0]), .serial_in_error(errOut[0])
    );
    uart_rx #(.CLKS_PER_BIT(CPB1)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx(rxLine[1]),
        .serial_data_in(dataOut[1]), .serial_in_cplt(cpltOut[1]), .serial_in_error(errOut[1])
    );
    uart_rx #(.CLKS_PER_BIT(CPB2)) dut2 (
        .clk(clk), .rst_n(rst_n), .rx(rxLine[2]),
        .serial_data_in(dataOut[2]), .serial_in_cplt(cpltOut[2]), .serial_in_error(errOut[2])
    );

    // Every strobe-high cycle becomes one observed event, so a stretched pulse shows up as extras.
    always @(posedge clk) begin
        evt_t e;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (cpltOut[i] === 1'b1) begin
                e.sel = i; e.kind = 1; e.cyc = cycle; e.data = dataOut[i];
                obsQ.push_back(e);
            end
            if (errOut[i] === 1'b1) begin
                e.sel = i; e.kind = 2; e.cyc = cycle; e.data = dataOut[i];
                obsQ.push_back(e);
            end
        end
    end

    function automatic int cpbOf(input int sel);
        case (sel)
            0:       return CPB0;
            1:       return CPB1;
            default: return CPB2;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Called at 1 time unit past a rising edge; holds the level for ncyc whole cycles.
    task automatic driveLevel(input int sel, input logic v, input int ncyc);
        rxLine[sel] = v;
        repeat (ncyc) begin
            @(posedge clk);
            #1;
        end
    endtask

    // The pin edge reaches the FSM two cycles later; the strobe follows the stop sample by one.
    task automatic sendFrame(input int sel, input logic [7:0] value, input logic stopBit, input int holdLowExtra);
        int   cpb;
        evt_t e;
        cpb   = cpbOf(sel);
        e.sel = sel;
        e.cyc = cycle + 2 + cpb / 2 + 9 * cpb + 1;
        if (stopBit) begin
            e.kind        = 1;
            e.data        = value;
            lastGood[sel] = value;
        end else begin
            e.kind = 2;
            e.data = lastGood[sel];
        end
        expQ.push_back(e);
        driveLevel(sel, 1'b0, cpb);
        for (int k = 0; k < 8; k++) driveLevel(sel, value[k], cpb);
        driveLevel(sel, stopBit, cpb + (stopBit ? 0 : holdLowExtra));
    endtask

    task automatic sendGlitch(input int sel, input int lowCycles);
        driveLevel(sel, 1'b0, lowCycles);
        driveLevel(sel, 1'b1, cpbOf(sel) / 2 + 2);
    endtask

    task automatic compareEvents(input string tag);
        int n;
        checkOutput({tag, ".count"}, 32'(obsQ.size()), 32'(expQ.size()));
        n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s.ev%0d.dut", tag, i),   32'(obsQ[i].sel),  32'(expQ[i].sel));
            checkOutput($sformatf("%s.ev%0d.kind", tag, i),  32'(obsQ[i].kind), 32'(expQ[i].kind));
            checkOutput($sformatf("%s.ev%0d.cycle", tag, i), 32'(obsQ[i].cyc),  32'(expQ[i].cyc));
            checkOutput($sformatf("%s.ev%0d.data", tag, i),  32'(obsQ[i].data), 32'(expQ[i].data));
        end
        expQ.delete();
        obsQ.delete();
    endtask

    task automatic applyStimulus();
        int   pick;
        int   relCycle;
        evt_t e;

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rxLine[i]   = 1'b1;
            lastGood[i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("reset.data%0d", i), 32'(dataOut[i]), 32'h00);
            checkOutput($sformatf("reset.cplt%0d", i), 32'(cpltOut[i]), 32'h0);
            checkOutput($sformatf("reset.err%0d", i),  32'(errOut[i]),  32'h0);
        end
        rst_n = 1'b1;
        driveLevel(0, 1'b1, 5);

        sendFrame(0, 8'h00, 1'b1, 0);
        driveLevel(0, 1'b1, 20);
        compareEvents("zeroByte");

        sendFrame(0, 8'hA5, 1'b1, 0);
        sendFrame(0, 8'h01, 1'b1, 0);
        driveLevel(0, 1'b1, 20);
        compareEvents("backToBack");

        sendGlitch(0, 4);
        sendFrame(0, 8'h3C, 1'b1, 0);
        driveLevel(0, 1'b1, 20);
        compareEvents("glitch");

        sendFrame(0, 8'h11, 1'b1, 0);
        driveLevel(0, 1'b1, 3);
        sendFrame(0, 8'h55, 1'b0, 100);
        driveLevel(0, 1'b1, 10);
        sendFrame(0, 8'h3C, 1'b1, 0);
        driveLevel(0, 1'b1, 20);
        compareEvents("framingErr");

        for (int it = 0; it < 10; it++) begin
            pick = int'($urandom_range(0, 3));
            case (pick)
                0, 1: begin
                    sendFrame(0, 8'($urandom), 1'b1, 0);
                    driveLevel(0, 1'b1, int'($urandom_range(0, 3)));
                end
                2: sendGlitch(0, int'($urandom_range(1, CPB0 / 2)));
                default: begin
                    sendFrame(0, 8'($urandom), 1'b0, int'($urandom_range(0, 30)));
                    driveLevel(0, 1'b1, int'($urandom_range(2, 6)));
                end
            endcase
        end
        driveLevel(0, 1'b1, 20);
        compareEvents("random16");

        // Abandon a 0xFF frame half-way through data bit 4.
        driveLevel(0, 1'b0, CPB0);
        for (int k = 0; k < 4; k++) driveLevel(0, 1'b1, CPB0);
        driveLevel(0, 1'b1, CPB0 / 2);
        rst_n = 1'b0;
        #1;
        checkOutput("midReset.data", 32'(dataOut[0]), 32'h00);
        checkOutput("midReset.cplt", 32'(cpltOut[0]), 32'h0);
        checkOutput("midReset.err",  32'(errOut[0]),  32'h0);
        for (int i = 0; i < 3; i++) lastGood[i] = 8'h00;
        @(posedge clk);
        #1;
        rxLine[0] = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n    = 1'b1;
        relCycle = cycle;
        e.sel  = 0;
        e.kind = 2;
        e.cyc  = relCycle + 2 + CPB0 / 2 + 9 * CPB0 + 1;
        e.data = 8'h00;
        expQ.push_back(e);
        driveLevel(0, 1'b0, 12 * CPB0);
        driveLevel(0, 1'b1, 10);
        sendFrame(0, 8'h7E, 1'b1, 0);
        driveLevel(0, 1'b1, 20);
        compareEvents("resetRecovery");

        for (int sel = 1; sel < 3; sel++) begin
            driveLevel(sel, 1'b1, 5);
            sendFrame(sel, 8'hC3, 1'b1, 0);
            for (int it = 0; it < 4; it++) begin
                if ($urandom_range(0, 3) == 0) begin
                    sendGlitch(sel, int'($urandom_range(1, cpbOf(sel) / 2)));
                end else begin
                    sendFrame(sel, 8'($urandom), 1'b1, 0);
                    driveLevel(sel, 1'b1, int'($urandom_range(0, 2)));
                end
            end
            driveLevel(sel, 1'b1, cpbOf(sel) + 6);
            compareEvents($sformatf("sweep%0d", cpbOf(sel)));
        end
    endtask

    initial begin
        applyStimulus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
